afifo_wr_arb: RTL and testbench
===============================

// Module: afifo_wr_arb
// PURPOSE
//   Round-robin burst arbiter that shares the write port of one afifo between NREQ
//   requesters. Each requester uses a valid/ready handshake. The block sits in the
//   afifo write-clock domain and drives wr/wr_dat from registers.
//   It throttles on the FIFO full/almost_full flags.
// PARAMETERS
//   NREQ    4  number of requesters
//   REQWID  2  clog2(NREQ), width of the grant index
//   BITWID  8  data width; matches afifo BITWID
//   BURST   4  max beats per grant (>=1)
//   CNTWID  16 width of per-requester beat counters (AFIFO_ARB_CNT_EN only)
// PORTS
//   clk               in   1             afifo wr_clk
//   rst               in   1             synchronous, active-high reset
//   req_vld           in   NREQ          requester i has a beat
//   req_dat           in   NREQ*BITWID   requester i data at [i*BITWID +: BITWID]
//   req_rdy           out  NREQ          beat of requester i accepted this cycle
//   fifo_wr           out  1             to afifo wr (registered)
//   fifo_wr_dat       out  BITWID        to afifo wr_dat (registered)
//   fifo_full         in   1             afifo full (includes wr lookahead)
//   fifo_almost_full  in   1             afifo almost_full
//   gnt_vld           out  1             a burst is in progress
//   gnt_idx           out  REQWID        index of the granted requester
//   beat_cnt          out  NREQ*CNTWID   accepted-beat counters (AFIFO_ARB_CNT_EN only)
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge):
//     - state=IDLE; fifo_wr=0; fifo_wr_dat=0; gnt_vld=0; gnt_idx=0; last=NREQ-1
//     - req_rdy=0 combinationally while in IDLE
//     - asserting reset mid-burst aborts the burst; a beat accepted in that cycle is dropped
//   FSM IDLE:
//     - if |req_vld and !fifo_almost_full: pick the first i with req_vld[i]=1,
//       searching i = last+1 .. last+NREQ mod NREQ
//     - latch gnt_idx=i, last=i, burst count=0; move to XFER next cycle
//     - no beat is accepted in IDLE, so grant latency is 1 cycle
//   FSM XFER:
//     - req_rdy[gnt_idx] = req_vld[gnt_idx] & !fifo_full; all other req_rdy = 0
//     - a beat is a cycle with req_vld & req_rdy on gnt_idx; next edge loads fifo_wr=1 and
//       fifo_wr_dat=beat data, otherwise fifo_wr=0; data reaches the FIFO 1 cycle after the handshake
//     - fifo_wr is a flop, so there is no combinational loop through the afifo full lookahead
//     - fifo_full mid-burst stalls the burst; the burst count holds and no timeout applies
//     - return to IDLE when a beat makes count==BURST, or when req_vld[gnt_idx]==0
//       (early release, no beat that cycle)
//     - one IDLE bubble always separates bursts
//   gnt_vld = (state==XFER).
//   Fairness:
//     - last updates only on grant; a requester that releases early loses its turn
//     - each requester is granted within NREQ-1 other bursts
//   Width rule: the burst count is clog2(BURST+1) bits and never wraps.
// CONFIGURATION
//   `AFIFO_ARB_CNT_EN defined:
//     - beat_cnt[i] increments by 1 on each accepted beat of requester i
//     - wraps at 2^CNTWID; rst clears it to 0
//   `AFIFO_ARB_CNT_EN not defined:
//     - beat_cnt is absent from the port list; no counter logic is built
// STRUCTURE
//   Package afifo_arb_pkg:
//     - FSM state localparams ST_IDLE=1'b0 and ST_XFER=1'b1
//     - clog2 function
//     - default CNTWID
//   Sub-module afifo_rr_pick (combinational):
//     - inputs req[NREQ] and last[REQWID]
//     - outputs any and idx[REQWID]
//     - instanced once, in the IDLE decision
// TESTING
//   1. rst=1 for 2 cycles with req_vld=4'hF -> req_rdy=0, fifo_wr=0, gnt_vld=0, gnt_idx=0
//   2. Only req0 valid, data 8'hA0..A5, fifo never full
//      -> bursts of 4 (A0-A3) then 2 (A4,A5)
//      -> fifo_wr high 4 cycles, 1+ cycle gap, then 2 cycles; data in order
//   3. req_vld=4'hF continuously, BURST=4
//      -> grant order 0,1,2,3,0...; exactly 4 beats each; no requester starved
//   4. fifo_full forced high for 3 cycles after the 2nd beat of a burst
//      -> req_rdy low for those 3 cycles; beats 3-4 follow; 4 beats total, none lost or duplicated
//   5. fifo_almost_full=1 in IDLE with req_vld=4'h2
//      -> gnt_vld stays 0; grant to idx 1 one cycle after almost_full falls
//   6. rst pulse during a beat in XFER -> the next cycle has fifo_wr=0 and state IDLE
//      -> with CNT_EN, beat_cnt is all 0 and the next grant goes to idx 0

Source files
------------

// File: rtl/afifo_arb_pkg.sv
// Shared definitions for the afifo write-port arbiter: FSM state encoding,
// default counter width and a constant clog2 helper.
package afifo_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    localparam int CNTWID_DFLT = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/afifo_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from last+1 (wrapping), so the previous winner has lowest priority.
module afifo_rr_pick
    import afifo_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int REQWID = clog2(NREQ)
) (
    input  logic [NREQ-1:0]   req,
    input  logic [REQWID-1:0] last,
    output logic              any,
    output logic [REQWID-1:0] idx
);

    logic [REQWID-1:0] w_cand;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        any    = |req;
        idx    = '0;
        w_cand = '0;
        // Scan farthest-first so the closest requester after last wins.
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = REQWID'((int'(last) + k) % NREQ);
            if (req[w_cand]) idx = w_cand;
        end
    end

endmodule

// File: rtl/afifo_wr_arb.sv
// Round-robin burst arbiter sharing one afifo write port between NREQ
// valid/ready requesters. Optional per-requester beat counters: AFIFO_ARB_CNT_EN.
module afifo_wr_arb
    import afifo_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int REQWID = clog2(NREQ),
    parameter int BITWID = 8,
    parameter int BURST  = 4,
    parameter int CNTWID = CNTWID_DFLT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_vld,
    input  logic [NREQ*BITWID-1:0]   req_dat,
    output logic [NREQ-1:0]          req_rdy,
    output logic                     fifo_wr,
    output logic [BITWID-1:0]        fifo_wr_dat,
    input  logic                     fifo_full,
    input  logic                     fifo_almost_full,
    output logic                     gnt_vld,
    output logic [REQWID-1:0]        gnt_idx
`ifdef AFIFO_ARB_CNT_EN
    ,
    output logic [NREQ*CNTWID-1:0]   beat_cnt
`endif
);

    localparam int BCWID = clog2(BURST + 1);
    localparam logic [BCWID-1:0] BURST_LAST = BCWID'(BURST);

    arb_state_e        r_state, w_state_nxt;
    logic [REQWID-1:0] r_gnt_idx, w_gnt_idx_nxt;
    logic [REQWID-1:0] r_last, w_last_nxt;
    logic [BCWID-1:0]  r_bcnt, w_bcnt_nxt;
    logic              r_fifo_wr;
    logic [BITWID-1:0] r_fifo_wr_dat;

    logic              w_pick_any;
    logic [REQWID-1:0] w_pick_idx;
    logic              w_gnt_req;
    logic              w_beat;
    logic [BITWID-1:0] w_req_dat [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_req_dat[gi] = req_dat[gi*BITWID +: BITWID];
    end

    afifo_rr_pick #(
        .NREQ   (NREQ),
        .REQWID (REQWID)
    ) u_pick (
        .req  (req_vld),
        .last (r_last),
        .any  (w_pick_any),
        .idx  (w_pick_idx)
    );

    assign w_gnt_req = req_vld[r_gnt_idx];
    assign w_beat    = (r_state == ST_XFER) && w_gnt_req && !fifo_full;

    always_comb begin
        req_rdy            = '0;
        req_rdy[r_gnt_idx] = w_beat;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_idx_nxt = r_gnt_idx;
        w_last_nxt    = r_last;
        w_bcnt_nxt    = r_bcnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any && !fifo_almost_full) begin
                    w_state_nxt   = ST_XFER;
                    w_gnt_idx_nxt = w_pick_idx;
                    w_last_nxt    = w_pick_idx;
                    w_bcnt_nxt    = '0;
                end
            end
            ST_XFER: begin
                // A stalled beat (fifo_full) holds the count; a dropped valid ends the burst.
                if (!w_gnt_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_beat) begin
                    w_bcnt_nxt = r_bcnt + 1'b1;
                    if (w_bcnt_nxt == BURST_LAST) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_gnt_idx     <= '0;
            r_last        <= REQWID'(NREQ - 1);
            r_bcnt        <= '0;
            r_fifo_wr     <= 1'b0;
            r_fifo_wr_dat <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_last    <= w_last_nxt;
            r_bcnt    <= w_bcnt_nxt;
            r_fifo_wr <= w_beat;
            if (w_beat) r_fifo_wr_dat <= w_req_dat[r_gnt_idx];
        end
    end

    assign fifo_wr     = r_fifo_wr;
    assign fifo_wr_dat = r_fifo_wr_dat;
    assign gnt_vld     = (r_state == ST_XFER);
    assign gnt_idx     = r_gnt_idx;

`ifdef AFIFO_ARB_CNT_EN
    logic [CNTWID-1:0] r_beat_cnt [NREQ];

    // NOTE: this array holds architectural counts, so unlike a data RAM it is reset explicitly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) r_beat_cnt[i] <= '0;
        end else if (w_beat) begin
            r_beat_cnt[r_gnt_idx] <= r_beat_cnt[r_gnt_idx] + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
        assign beat_cnt[gi*CNTWID +: CNTWID] = r_beat_cnt[gi];
    end
`endif

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Directed bench for afifo_wr_arb: reset, single requester bursts, round robin,
// full stall, almost_full gating and reset mid-burst.
module tb_afifo_wr_arb;

    localparam int NREQ   = 4;
    localparam int REQWID = 2;
    localparam int BITWID = 8;
    localparam int BURST  = 4;
    localparam int CNTWID = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_vld = '0;
    logic [NREQ*BITWID-1:0] req_dat = '0;
    logic [NREQ-1:0]        req_rdy;
    logic                   fifo_wr;
    logic [BITWID-1:0]      fifo_wr_dat;
    logic                   fifo_full = 1'b0;
    logic                   fifo_almost_full = 1'b0;
    logic                   gnt_vld;
    logic [REQWID-1:0]      gnt_idx;
`ifdef AFIFO_ARB_CNT_EN
    logic [NREQ*CNTWID-1:0] beat_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    int         src_left [NREQ];
    logic [7:0] src_dat  [NREQ];
    int         hs_total;
    int         full_trigger;
    int         full_left;
    int         stall_cycles;
    logic [7:0] wr_q [$];
    int         gnt_q [$];
    bit         wr_log [$];

    afifo_wr_arb #(
        .NREQ   (NREQ),
        .REQWID (REQWID),
        .BITWID (BITWID),
        .BURST  (BURST),
        .CNTWID (CNTWID)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_vld          (req_vld),
        .req_dat          (req_dat),
        .req_rdy          (req_rdy),
        .fifo_wr          (fifo_wr),
        .fifo_wr_dat      (fifo_wr_dat),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .gnt_vld          (gnt_vld),
        .gnt_idx          (gnt_idx)
`ifdef AFIFO_ARB_CNT_EN
        ,
        .beat_cnt         (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_src();
        for (int i = 0; i < NREQ; i++) begin
            req_vld[i] = (src_left[i] > 0);
            req_dat[i*BITWID +: BITWID] = src_dat[i];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_vld = '0;
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wr_q.delete();
        gnt_q.delete();
        wr_log.delete();
        hs_total = 0;
        full_trigger = -1;
        full_left = 0;
        stall_cycles = 0;
        for (int i = 0; i < NREQ; i++) begin
            src_left[i] = 0;
            src_dat[i]  = '0;
        end
    endtask

    // Cycle loop: sample outputs at negedge, advance the requester sources after the posedge.
    task automatic run_cycles(input int n);
        bit prev_gnt;
        logic [NREQ-1:0] rdy_s;
        prev_gnt = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rdy_s = req_rdy;
            if (fifo_wr) wr_q.push_back(fifo_wr_dat);
            wr_log.push_back(fifo_wr);
            if (gnt_vld && !prev_gnt) gnt_q.push_back(int'(gnt_idx));
            prev_gnt = gnt_vld;
            if (fifo_full && gnt_vld && req_vld[gnt_idx]) begin
                stall_cycles++;
                tests_run++;
                if (rdy_s !== '0) begin
                    tests_failed++;
                    $display("FAIL stall_rdy: req_rdy=%b while full, expected 0000", rdy_s);
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (rdy_s[i] && req_vld[i]) begin
                    src_left[i]--;
                    src_dat[i]++;
                    hs_total++;
                    if (hs_total == full_trigger) full_left = 3;
                end
            end
            if (full_left > 0) begin
                fifo_full = 1'b1;
                full_left--;
            end else begin
                fifo_full = 1'b0;
            end
            apply_src();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_vld = 4'hF;
        req_dat = 32'h1234_5678;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (req_rdy !== 4'h0) begin
                tests_failed++;
                $display("FAIL reset_rdy: got %b expected 0000", req_rdy);
            end
            tests_run++;
            if (fifo_wr !== 1'b0 || fifo_wr_dat !== 8'h00) begin
                tests_failed++;
                $display("FAIL reset_wr: got wr=%b dat=%h expected 0/00", fifo_wr, fifo_wr_dat);
            end
            tests_run++;
            if (gnt_vld !== 1'b0 || gnt_idx !== 2'd0) begin
                tests_failed++;
                $display("FAIL reset_gnt: got vld=%b idx=%0d expected 0/0", gnt_vld, gnt_idx);
            end
        end
        req_vld = '0;
    endtask

    task automatic test_single_req();
        int runs [$];
        int cur;
        do_reset();
        src_left[0] = 6;
        src_dat[0]  = 8'hA0;
        apply_src();
        run_cycles(16);
        tests_run++;
        if (wr_q.size() != 6) begin
            tests_failed++;
            $display("FAIL single_count: got %0d writes expected 6", wr_q.size());
        end
        for (int k = 0; k < 6 && k < wr_q.size(); k++) begin
            tests_run++;
            if (wr_q[k] !== 8'hA0 + 8'(k)) begin
                tests_failed++;
                $display("FAIL single_data[%0d]: got %h expected %h", k, wr_q[k], 8'hA0 + 8'(k));
            end
        end
        cur = 0;
        foreach (wr_log[j]) begin
            if (wr_log[j]) cur++;
            else if (cur > 0) begin
                runs.push_back(cur);
                cur = 0;
            end
        end
        if (cur > 0) runs.push_back(cur);
        tests_run++;
        if (runs.size() != 2 || runs[0] != 4 || runs[1] != 2) begin
            tests_failed++;
            $display("FAIL single_bursts: got %0d runs (first %0d) expected 2 runs 4,2",
                     runs.size(), (runs.size() > 0) ? runs[0] : -1);
        end
        tests_run++;
        if (gnt_q.size() != 2) begin
            tests_failed++;
            $display("FAIL single_grants: got %0d grants expected 2", gnt_q.size());
        end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            src_left[i] = 8;
            src_dat[i]  = 8'(i * 16);
        end
        apply_src();
        run_cycles(60);
        tests_run++;
        if (gnt_q.size() != 8) begin
            tests_failed++;
            $display("FAIL rr_grants: got %0d grants expected 8", gnt_q.size());
        end
        for (int j = 0; j < 8 && j < gnt_q.size(); j++) begin
            tests_run++;
            if (gnt_q[j] != j % 4) begin
                tests_failed++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", j, gnt_q[j], j % 4);
            end
        end
        tests_run++;
        if (wr_q.size() != 32) begin
            tests_failed++;
            $display("FAIL rr_count: got %0d writes expected 32", wr_q.size());
        end
        n = 0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++)
                for (int k = 0; k < BURST; k++) begin
                    if (n < wr_q.size()) begin
                        tests_run++;
                        if (wr_q[n] !== 8'(i * 16 + r * 4 + k)) begin
                            tests_failed++;
                            $display("FAIL rr_data[%0d]: got %h expected %h", n, wr_q[n],
                                     8'(i * 16 + r * 4 + k));
                        end
                    end
                    n++;
                end
    endtask

    task automatic test_full_stall();
        do_reset();
        src_left[2]  = 4;
        src_dat[2]   = 8'hC0;
        full_trigger = 2;
        apply_src();
        run_cycles(20);
        tests_run++;
        if (stall_cycles != 3) begin
            tests_failed++;
            $display("FAIL stall_cycles: got %0d expected 3", stall_cycles);
        end
        tests_run++;
        if (wr_q.size() != 4) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d writes expected 4", wr_q.size());
        end
        for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
            tests_run++;
            if (wr_q[k] !== 8'hC0 + 8'(k)) begin
                tests_failed++;
                $display("FAIL stall_data[%0d]: got %h expected %h", k, wr_q[k], 8'hC0 + 8'(k));
            end
        end
        tests_run++;
        if (gnt_q.size() != 1 || gnt_q[0] != 2) begin
            tests_failed++;
            $display("FAIL stall_grant: got %0d grants (first %0d) expected 1 grant to 2",
                     gnt_q.size(), (gnt_q.size() > 0) ? gnt_q[0] : -1);
        end
    endtask

    task automatic test_almost_full();
        do_reset();
        fifo_almost_full = 1'b1;
        req_vld = 4'h2;
        req_dat = 32'h0000_5A00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (gnt_vld !== 1'b0) begin
                tests_failed++;
                $display("FAIL afull_hold[%0d]: gnt_vld=%b expected 0", c, gnt_vld);
            end
        end
        @(posedge clk);
        #1 fifo_almost_full = 1'b0;
        @(negedge clk);
        tests_run++;
        if (gnt_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL afull_fall: gnt_vld=%b expected 0", gnt_vld);
        end
        @(negedge clk);
        tests_run++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 2'd1) begin
            tests_failed++;
            $display("FAIL afull_grant: got vld=%b idx=%0d expected 1/1", gnt_vld, gnt_idx);
        end
        req_vld = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_vld = 4'b0010;
        req_dat = 32'h0000_5500;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        tests_run++;
        if (fifo_wr !== 1'b1 || fifo_wr_dat !== 8'h55) begin
            tests_failed++;
            $display("FAIL rstmid_first: got wr=%b dat=%h expected 1/55", fifo_wr, fifo_wr_dat);
        end
`ifdef AFIFO_ARB_CNT_EN
        tests_run++;
        if (beat_cnt[1*CNTWID +: CNTWID] !== 16'd1) begin
            tests_failed++;
            $display("FAIL rstmid_cnt1: got %0d expected 1", beat_cnt[1*CNTWID +: CNTWID]);
        end
`endif
        req_dat = 32'h0000_5600;
        rst = 1'b1;
        #1;
        tests_run++;
        if (req_rdy !== 4'b0010) begin
            tests_failed++;
            $display("FAIL rstmid_rdy: got %b expected 0010", req_rdy);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (fifo_wr !== 1'b0 || gnt_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_abort: got wr=%b gnt_vld=%b expected 0/0", fifo_wr, gnt_vld);
        end
`ifdef AFIFO_ARB_CNT_EN
        tests_run++;
        if (beat_cnt !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_cnt0: got %h expected 0", beat_cnt);
        end
`endif
        rst = 1'b0;
        req_vld = 4'b0011;
        @(posedge clk);
        #1;
        tests_run++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 2'd0) begin
            tests_failed++;
            $display("FAIL rstmid_regrant: got vld=%b idx=%0d expected 1/0", gnt_vld, gnt_idx);
        end
        req_vld = '0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single_req();
        test_round_robin();
        test_full_stall();
        test_almost_full();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
